store_buffer_datapath: RTL and testbench
========================================

// Module: store_buffer_datapath
// PURPOSE
//   Write-side counterpart of the load datapath in the MEM stage.
//   - Takes store requests (SB/SH/SW), checks alignment, lane-aligns data, generates byte strobes.
//   - Queues accepted stores in a small FIFO and drains them to data memory over a req/ack handshake.
//   - Flags loads that hit a pending store word so the hazard unit can stall them.
// PARAMETERS
//   DEPTH   4   store buffer entries; power of 2, >= 2
//   CNT_W   3   width of occupancy count; must hold DEPTH (log2(DEPTH)+1)
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   st_valid       in   1   store request valid
//   st_ready       out  1   buffer can accept (= count < DEPTH, registered state only)
//   store_type     in   3   000=SB 001=SH 010=SW; other codes illegal
//   addr           in   32  byte address from ALU
//   store_data     in   32  rs2 value
//   st_err         out  1   1-cycle pulse: accepted request was misaligned or illegal
//   err_addr       out  32  byte address of the last errored request
//   mem_req        out  1   head entry valid toward memory
//   mem_ack        in   1   memory accepted head entry this cycle
//   mem_addr       out  32  word address of head, bits [1:0] = 00
//   mem_wdata      out  32  lane-aligned write data of head
//   mem_wstrb      out  4   byte enables of head, bit i = byte lane i
//   ld_addr        in   32  address of the load currently in MEM
//   ld_conflict    out  1   combinational: a valid entry has mem_addr[31:2] == ld_addr[31:2]
//   buf_empty      out  1   count == 0 (fence / drain indicator)
//   count          out  CNT_W  current occupancy
// BEHAVIOUR
//   - Single clock clk; reset rst is synchronous, active-high.
//   - Reset: count=0, rd/wr pointers=0, mem_req=0, st_err=0, err_addr=0, buf_empty=1.
//     - Reset mid-operation discards all buffered stores, including one being presented on mem_req.
//   - Accept: st_valid && st_ready at a rising edge.
//     - A legal, aligned request is pushed.
//     - Errored requests are consumed (st_ready honoured) but never pushed.
//   - Encoding, ofs = addr[1:0]:
//     SB : wdata = {4{store_data[7:0]}};  wstrb = 4'b0001 << ofs;  always aligned
//     SH : wdata = {2{store_data[15:0]}}; wstrb = ofs[1] ? 4'b1100 : 4'b0011;  misaligned if ofs[0]
//     SW : wdata = store_data;            wstrb = 4'b1111;  misaligned if ofs != 0
//     illegal store_type (011..111): error
//   - Error: st_err=1 for exactly the cycle after acceptance; err_addr <= addr in that same update.
//     - count unchanged by an errored request.
//   - Latency: a pushed store is visible on mem_req/mem_* the cycle after acceptance at the earliest.
//     - No combinational path from st_* to mem_*.
//   - Drain:
//     - mem_req = (count != 0).
//     - mem_addr/mem_wdata/mem_wstrb come from the head entry and stay stable while mem_req && !mem_ack.
//     - Pop on mem_req && mem_ack; mem_ack with mem_req=0 is ignored.
//   - Ordering: strict FIFO; stores reach memory in acceptance order.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//     - When full, st_ready=0 even if mem_ack pops this cycle; there is no same-cycle pass-through.
//   - Pointers wrap modulo DEPTH.
//   - ld_conflict: compare against all valid entries only.
//     - A store being accepted this cycle is not yet compared.
//     - A head entry being acked this cycle still counts.
// TESTING
//   1. Reset: assert rst 2 cycles with st_valid=1 -> mem_req=0, count=0, st_err=0, buf_empty=1.
//   2. SB addr=0x1003, data=0xA1B2C3D4, mem_ack=0 ->
//      next cycle mem_req=1, mem_addr=0x1000, mem_wdata=0xD4D4D4D4, mem_wstrb=4'b1000.
//      Then ack -> count=0.
//   3. SH addr=0x2002, data=0x0000BEEF -> wdata=0xBEEFBEEF, wstrb=4'b1100.
//      SH addr=0x2001 -> st_err pulse, err_addr=0x2001, count unchanged.
//   4. Fill: 4 SW to 0x10,0x14,0x18,0x1C with mem_ack=0 -> count=4, st_ready=0.
//      Then ack each cycle -> memory sees 0x10,0x14,0x18,0x1C in order; st_ready returns 1 after the first pop.
//   5. Push while ack at count=2 -> count stays 2.
//      Then 10 random pushes/pops -> pointers wrap, data order preserved.
//   6. Pending SW at 0x40, ld_addr=0x43 -> ld_conflict=1; ld_addr=0x44 -> 0.
//      Reset with 3 pending -> all discarded, mem_req=0 next cycle.

Source files
------------

// File: rtl/store_buffer_datapath.sv
// Store side of the MEM stage: lane-aligns SB/SH/SW requests into word writes, queues them
// in a small FIFO drained over mem_req/mem_ack, and flags loads that hit a pending store word.
module store_buffer_datapath #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [2:0]       store_type,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  output logic             st_err,
  output logic [31:0]      err_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic             buf_empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [29:0]      word_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [3:0]       strb_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             st_err_r;
  logic [31:0]      err_addr_r;

  logic [31:0]      enc_wdata_s;
  logic [3:0]       enc_wstrb_s;
  logic             enc_err_s;
  logic             st_ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             conflict_s;

  // Lane-align store data, build byte strobes and detect illegal or misaligned requests
  always_comb begin
    enc_wdata_s = store_data;
    enc_wstrb_s = 4'b0000;
    enc_err_s   = 1'b0;
    case (store_type)
      3'b000: begin
        enc_wdata_s = {4{store_data[7:0]}};
        enc_wstrb_s = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        enc_wdata_s = {2{store_data[15:0]}};
        enc_wstrb_s = addr[1] ? 4'b1100 : 4'b0011;
        enc_err_s   = addr[0];
      end
      3'b010: begin
        enc_wstrb_s = 4'b1111;
        enc_err_s   = (addr[1:0] != 2'b00);
      end
      default: enc_err_s = 1'b1;
    endcase
  end

  // Handshake decode; ready looks only at registered occupancy, so a full buffer never passes through
  always_comb begin
    st_ready_s = (count_r < DEPTH_C);
    accept_s   = st_valid && st_ready_s;
    push_s     = accept_s && !enc_err_s;
    pop_s      = (count_r != {CNT_W{1'b0}}) && mem_ack;
  end

  // Pointers, occupancy and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      st_err_r   <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
      st_err_r <= accept_s && enc_err_s;
      if (accept_s && enc_err_s) begin
        err_addr_r <= addr;
      end
    end
  end

  // Entry storage; cleared on reset so discarded stores leave no stale contents behind
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_r[i] <= 30'h0;
        data_r[i] <= 32'h0000_0000;
        strb_r[i] <= 4'b0000;
      end
    end else if (push_s) begin
      word_r[wr_ptr_r] <= addr[31:2];
      data_r[wr_ptr_r] <= enc_wdata_s;
      strb_r[wr_ptr_r] <= enc_wstrb_s;
    end
  end

  // An entry is valid when its distance from the head is below the occupancy
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(i) - rd_ptr_r) < count_r) && (word_r[i] == ld_addr[31:2])) begin
        conflict_s = 1'b1;
      end else begin
        conflict_s = conflict_s;
      end
    end
  end

  assign st_ready    = st_ready_s;
  assign st_err      = st_err_r;
  assign err_addr    = err_addr_r;
  assign mem_req     = (count_r != {CNT_W{1'b0}});
  assign mem_addr    = {word_r[rd_ptr_r], 2'b00};
  assign mem_wdata   = data_r[rd_ptr_r];
  assign mem_wstrb   = strb_r[rd_ptr_r];
  assign ld_conflict = conflict_s;
  assign buf_empty   = (count_r == {CNT_W{1'b0}});
  assign count       = count_r;

endmodule

// File: tb/tb_store_buffer_datapath.sv
// Self-checking bench for store_buffer_datapath: encoding vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_store_buffer_datapath;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [2:0]       store_type = 3'd0;
  logic [31:0]      addr = 32'h0;
  logic [31:0]      store_data = 32'h0;
  logic             st_err;
  logic [31:0]      err_addr;
  logic             mem_req;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      ld_addr = 32'h0;
  logic             ld_conflict;
  logic             buf_empty;
  logic [CNT_W-1:0] count;

  store_buffer_datapath #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .store_type(store_type), .addr(addr), .store_data(store_data),
    .st_err(st_err), .err_addr(err_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .buf_empty(buf_empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] wd;
    logic [3:0]  ws;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [31:0] drained[$];
  logic        exp_err = 1'b0;
  logic [31:0] exp_err_addr = 32'h0;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-lane view: lane i is written when it falls inside [ofs, ofs+size),
  // and carries source byte (i mod size) so the data is replicated across the word.
  function automatic void encode(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                                 output logic err, output logic [31:0] wd, output logic [3:0] ws);
    int size;
    int ofs;
    ofs = int'(a[1:0]);
    case (t)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      default: size = 0;
    endcase
    err = (size == 0) || ((ofs % ((size == 0) ? 1 : size)) != 0);
    wd = 32'h0;
    ws = 4'h0;
    if (size != 0) begin
      for (int i = 0; i < 4; i++) begin
        wd[8*i +: 8] = d[8*(i % size) +: 8];
        ws[i] = (i >= ofs) && (i < ofs + size);
      end
    end
  endfunction

  // One clock: check pre-edge outputs against the model, advance the model, check post-edge state.
  task automatic cycle();
    logic        err;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        acc;
    logic        pop;
    logic        conf;
    ent_t        e;
    #1;
    check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    check("mem_req", 32'(mem_req), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("mem_addr", mem_addr, q[0].a);
      check("mem_wdata", mem_wdata, q[0].d);
      check("mem_wstrb", 32'(mem_wstrb), 32'(q[0].s));
    end
    conf = 1'b0;
    foreach (q[i]) if (q[i].a[31:2] == ld_addr[31:2]) conf = 1'b1;
    check("ld_conflict", 32'(ld_conflict), 32'(conf));
    encode(store_type, addr, store_data, err, wd, ws);
    if (rst) begin
      q.delete();
      exp_err = 1'b0;
      exp_err_addr = 32'h0;
    end else begin
      acc = st_valid && (q.size() < DEPTH);
      pop = (q.size() != 0) && mem_ack;
      if (pop) begin
        drained.push_back(q[0].a);
        void'(q.pop_front());
      end
      exp_err = acc && err;
      if (acc && err) exp_err_addr = addr;
      if (acc && !err) begin
        e.a = {addr[31:2], 2'b00};
        e.d = wd;
        e.s = ws;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
    check("st_err", 32'(st_err), 32'(exp_err));
    check("err_addr", err_addr, exp_err_addr);
  endtask

  task automatic push(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d, input logic ack);
    st_valid = 1'b1;
    store_type = t;
    addr = a;
    store_data = d;
    mem_ack = ack;
    cycle();
    st_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'h0000_1003, 32'hA1B2_C3D4, 1'b0, 32'hD4D4_D4D4, 4'b1000};
    vecs[1] = '{3'd0, 32'h0000_2000, 32'h1234_5678, 1'b0, 32'h7878_7878, 4'b0001};
    vecs[2] = '{3'd0, 32'h0000_5001, 32'h0000_00A5, 1'b0, 32'hA5A5_A5A5, 4'b0010};
    vecs[3] = '{3'd1, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 32'hBEEF_BEEF, 4'b1100};
    vecs[4] = '{3'd1, 32'h0000_2000, 32'h1234_CAFE, 1'b0, 32'hCAFE_CAFE, 4'b0011};
    vecs[5] = '{3'd1, 32'h0000_2001, 32'h0000_BEEF, 1'b1, 32'h0,         4'b0000};
    vecs[6] = '{3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b1111};
    vecs[7] = '{3'd2, 32'h0000_3002, 32'hDEAD_BEEF, 1'b1, 32'h0,         4'b0000};
    vecs[8] = '{3'd3, 32'h0000_4000, 32'h1111_2222, 1'b1, 32'h0,         4'b0000};
    vecs[9] = '{3'd7, 32'h0000_4004, 32'h3333_4444, 1'b1, 32'h0,         4'b0000};

    // Reset held two cycles with a store presented
    rst = 1'b1;
    st_valid = 1'b1;
    store_type = 3'd2;
    addr = 32'h0000_0100;
    store_data = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_st_err", 32'(st_err), 32'd0);
    check("rst_buf_empty", 32'(buf_empty), 32'd1);
    check("rst_err_addr", err_addr, 32'h0);
    rst = 1'b0;
    st_valid = 1'b0;

    // Encoding table
    for (int k = 0; k < 10; k++) begin
      push(vecs[k].t, vecs[k].a, vecs[k].d, 1'b0);
      check("vec_st_err", 32'(st_err), 32'(vecs[k].err));
      if (vecs[k].err) begin
        check("vec_err_addr", err_addr, vecs[k].a);
        check("vec_count_err", 32'(count), 32'd0);
      end else begin
        check("vec_mem_req", 32'(mem_req), 32'd1);
        check("vec_mem_addr", mem_addr, {vecs[k].a[31:2], 2'b00});
        check("vec_mem_wdata", mem_wdata, vecs[k].wd);
        check("vec_mem_wstrb", 32'(mem_wstrb), 32'(vecs[k].ws));
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        check("vec_count_drained", 32'(count), 32'd0);
      end
    end

    // Fill, then drain in order; full buffer refuses a store even while popping
    for (int k = 0; k < 4; k++) push(3'd2, 32'h10 + 32'(4 * k), $urandom, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_st_ready", 32'(st_ready), 32'd0);
    drained.delete();
    push(3'd2, 32'h0000_0020, 32'h0BAD_0BAD, 1'b1);
    check("full_no_passthru", 32'(count), 32'd3);
    check("ready_after_pop", 32'(st_ready), 32'd1);
    mem_ack = 1'b1;
    repeat (3) cycle();
    mem_ack = 1'b0;
    check("drain_len", 32'(drained.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < drained.size()) check("drain_order", drained[k], 32'h10 + 32'(4 * k));
    end

    // Push while popping at count=2
    push(3'd2, 32'h0000_0080, 32'h0000_0001, 1'b0);
    push(3'd2, 32'h0000_0084, 32'h0000_0002, 1'b0);
    push(3'd2, 32'h0000_0088, 32'h0000_0003, 1'b1);
    check("push_pop_count", 32'(count), 32'd2);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      st_valid = $urandom_range(0, 1) == 1;
      store_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      store_data = $urandom;
      mem_ack = $urandom_range(0, 2) != 0;
      ld_addr = 32'h100 + 32'($urandom_range(0, 35));
      cycle();
    end
    rst = 1'b0;
    st_valid = 1'b0;
    mem_ack = 1'b1;
    repeat (DEPTH) cycle();
    mem_ack = 1'b0;
    check("rand_drained", 32'(count), 32'd0);

    // Load hazard against a pending word, then reset with three pending
    push(3'd2, 32'h0000_0040, 32'hCAFE_F00D, 1'b0);
    ld_addr = 32'h0000_0043;
    #1;
    check("ld_conflict_hit", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h0000_0044;
    #1;
    check("ld_conflict_miss", 32'(ld_conflict), 32'd0);
    push(3'd0, 32'h0000_0051, 32'h0000_0077, 1'b0);
    push(3'd1, 32'h0000_0062, 32'h0000_1234, 1'b0);
    check("pending3", 32'(count), 32'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
